hub75_bcm_scheduler: RTL and testbench
======================================

Name: hub75_bcm_scheduler

Overview:
Scan and timing controller for the 64x64 HUB75 PMOD LED panel (1/32 scan, top and bottom halves driven together).
Fetches pixel pairs from the framebuffer and shifts one bit plane of 64 columns into the panel. It then latches the plane and enables the outputs for a binary-weighted on-time (binary code modulation).
Sits between the framebuffer read port and the panel pins, and replaces free-running row/column counting with a sequenced scan.

Parameters:
ROWS, 32, scan rows; row_addr width = $clog2(ROWS)
COLS, 64, columns shifted per plane; col_addr width = $clog2(COLS)
COLOR_BITS, 4, bits per colour channel, i.e. number of bit planes
CLK_DIV, 2, clk cycles per display_clk half-period; must be >= 2
BASE_ON_CYCLES, 8, on-time of plane 0 in clk cycles

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  run request; sampled in IDLE and at frame end
fb_rd_en  out  1  framebuffer read strobe; data returns exactly 1 cycle later
fb_addr  out  11  {row, col} of the pixel pair being fetched
fb_rd_data  in  24  [23:12] top pixel {R,G,B}, [11:0] bottom pixel {R,G,B}; 4 bits each, MSB first
rgb_top  out  3  {R,G,B} bit of current plane, top half
rgb_bot  out  3  {R,G,B} bit of current plane, bottom half
display_clk  out  1  panel shift clock; panel samples on rising edge
latch  out  1  panel latch, active-high
oe  out  1  panel output enable, active-low (1 = blanked)
row_addr  out  5  displayed row
col_addr  out  6  column currently being shifted
frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) has priority and returns to IDLE immediately, including mid-shift or mid-display. Values after reset:
  - oe=1; latch=0; display_clk=0; fb_rd_en=0; frame_done=0
  - rgb_top=rgb_bot=0; row_addr=0; col_addr=0
  - internal row=0, plane=0
- State machine: IDLE -> FETCH -> CLK_LO -> CLK_HI -> (next column: FETCH | last column: BLANK) -> LATCH -> DISPLAY -> FETCH | IDLE.
- IDLE: all outputs at reset values. If enable=1, go to FETCH next cycle.
- FETCH (1 cycle): fb_rd_en=1, fb_addr={row, col}, col_addr=col, display_clk=0.
- CLK_LO (CLK_DIV cycles): display_clk=0; fb_rd_data is valid in the first CLK_LO cycle. At the end of that cycle, load:
  - rgb_top = {R_top[plane], G_top[plane], B_top[plane]}
  - rgb_bot from the bottom pixel in the same way
- CLK_HI (CLK_DIV cycles): display_clk=1; rgb stable. If col == COLS-1, go to BLANK with col=0; otherwise col+1 and go to FETCH.
- Shift phase length = COLS*(1+2*CLK_DIV) cycles (320 at defaults). oe stays 1 throughout, so nothing is displayed while shifting.
- BLANK (1 cycle): oe=1; row_addr<=row. row_addr may change only while oe=1.
- LATCH (1 cycle): latch=1, oe=1.
- DISPLAY (BASE_ON_CYCLES << plane cycles): oe=0, then advance:
  - if plane < COLOR_BITS-1: plane+1
  - else plane=0 and row+1
  - if row wraps from ROWS-1 to 0: frame_done=1 for the first cycle of the next state
- Next state after DISPLAY: IDLE if a frame just completed and enable=0; otherwise FETCH.
- enable=0 mid-frame has no effect; the frame always completes.
- Timing at defaults:
  - per plane: 322 + on-time cycles
  - per row: 4*322 + 8*(1+2+4+8) = 1408 cycles
  - per frame: 32*1408 = 45056 cycles
- Widths: the on-time counter must hold BASE_ON_CYCLES << (COLOR_BITS-1) without overflow. row, col and plane counters wrap exactly at ROWS, COLS and COLOR_BITS.

Decomposition:
- Package hub75_pkg holds:
  - state enum (IDLE, FETCH, CLK_LO, CLK_HI, BLANK, LATCH, DISPLAY)
  - ROW_W=5, COL_W=6, PIX_W=12
  - field offsets of the R/G/B nibbles within a pixel
- One sub-module is natural: hub75_shift_unit.
  - Owns the col counter, the CLK_DIV divider, the fb read strobe and the bit-plane select.
  - Interface: start pulse in, done pulse out.
- The top-level holds the row/plane sequencing and the on-time counter.

Test Plan:
1. Reset then enable=1 with defaults: first fb_rd_en 1 cycle after enable is sampled, with fb_addr=0. 64 display_clk rising edges follow, then latch high exactly 1 cycle, then oe=0 for exactly 8 cycles (plane 0).
2. Constant fb_rd_data=24'hF00_00F (top red=15, bottom blue=15): every sampled plane gives rgb_top=3'b100 and rgb_bot=3'b001 on each display_clk rise. Per-row oe-low durations are 8, 16, 32, 64 cycles in order.
3. Full frame: frame_done pulses after 45056 cycles. row_addr steps 0..31 and wraps to 0, changing only while oe=1. Check throughout: latch and oe=0 never overlap, and latch never coincides with display_clk=1.
4. Drop enable at row 10: scheduler finishes row 31, pulses frame_done, enters IDLE with oe=1, and issues no further fb_rd_en.
5. Assert rst for 1 cycle mid-DISPLAY of plane 3, row 5: the next cycle shows all reset values with oe=1. Re-enabling restarts at row 0, plane 0, fb_addr=0.
6. CLK_DIV=3, BASE_ON_CYCLES=4: display_clk high and low phases are 3 cycles each, the shift phase is 448 cycles, and plane on-times are 4, 8, 16, 32.

Source files
------------

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and constants for the HUB75 bit-plane scheduler.
//   state_t     - scan states used by the scheduler and its shift unit
//   ROW_W/COL_W - row/column address widths of the 64x64, 1/32-scan panel
//   PIX_W       - width of one {R,G,B} pixel in the framebuffer word
//   *_OFS       - bit offset of each colour nibble within a pixel
//   plane_bits  - picks one bit plane of a pixel as {R,G,B}
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CLK_LO,
        CLK_HI,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    localparam int ROW_W   = 5;
    localparam int COL_W   = 6;
    localparam int PIX_W   = 12;
    localparam int NIB_W   = 4;
    localparam int PLANE_W = 2;

    localparam int R_OFS = 8;
    localparam int G_OFS = 4;
    localparam int B_OFS = 0;

    function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0]   pix,
                                              input logic [PLANE_W-1:0] plane);
        logic [NIB_W-1:0] r, g, b;
        r = pix[R_OFS +: NIB_W];
        g = pix[G_OFS +: NIB_W];
        b = pix[B_OFS +: NIB_W];
        return {r[plane], g[plane], b[plane]};
    endfunction

endpackage

// File: rtl/hub75_shift_unit.sv
// hub75_shift_unit: shifts one bit plane of one row pair into the panel.
//   clk, rst          - system clock, synchronous active-high reset
//   start             - one-cycle pulse, begins a 64-column shift
//   row, plane        - row being fetched and bit plane being extracted
//   fb_rd_en, fb_addr - framebuffer read strobe and {row, col} address
//   fb_rd_data        - {top pixel, bottom pixel}, valid 1 cycle after fb_rd_en
//   col               - column currently being shifted
//   display_clk       - panel shift clock
//   rgb_top, rgb_bot  - selected plane bits for the current column
//   done              - one-cycle pulse in the last cycle of the last column
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | framebuffer read issued for {row, col}
// CLK_LO | display_clk low, CLK_DIV cycles; pixel bits captured in the first
// CLK_HI | display_clk high, CLK_DIV cycles; panel samples on the rise
module hub75_shift_unit
    import hub75_pkg::*;
#(
    parameter int COLS    = 64,
    parameter int CLK_DIV = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROW_W-1:0]         row,
    input  logic [PLANE_W-1:0]       plane,
    input  logic [2*PIX_W-1:0]       fb_rd_data,
    output logic                     fb_rd_en,
    output logic [ROW_W+COL_W-1:0]   fb_addr,
    output logic [COL_W-1:0]         col,
    output logic                     display_clk,
    output logic [2:0]               rgb_top,
    output logic [2:0]               rgb_bot,
    output logic                     done
);

    localparam int DIV_W = $clog2(CLK_DIV);

    state_t           phase_q, phase_d;
    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;
    logic             last_col;
    logic             first_lo;

    assign div_tc   = (div_cnt == '0);
    assign last_col = (col == COL_W'(COLS - 1));
    // Read data arrives exactly one cycle after FETCH, i.e. in the first CLK_LO cycle.
    assign first_lo = (phase_q == CLK_LO) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fb_addr  = {row, col};

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            IDLE:    if (start) phase_d = FETCH;
            FETCH:   phase_d = CLK_LO;
            CLK_LO:  if (div_tc) phase_d = CLK_HI;
            CLK_HI:  if (div_tc) phase_d = last_col ? IDLE : FETCH;
            default: phase_d = IDLE;
        endcase
    end

    always_comb begin
        fb_rd_en    = (phase_q == FETCH);
        display_clk = (phase_q == CLK_HI);
        done        = (phase_q == CLK_HI) && div_tc && last_col;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= DIV_W'(CLK_DIV - 1);
            col     <= '0;
            rgb_top <= '0;
            rgb_bot <= '0;
        end else begin
            if (phase_q == CLK_LO || phase_q == CLK_HI) begin
                div_cnt <= div_tc ? DIV_W'(CLK_DIV - 1) : div_cnt - DIV_W'(1);
            end
            if (phase_q == CLK_HI && div_tc) begin
                col <= last_col ? '0 : col + COL_W'(1);
            end
            if (first_lo) begin
                rgb_top <= plane_bits(fb_rd_data[2*PIX_W-1:PIX_W], plane);
                rgb_bot <= plane_bits(fb_rd_data[PIX_W-1:0], plane);
            end
        end
    end

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler: row/plane sequencer with binary-coded-modulation on-times
// for a 64x64 1/32-scan HUB75 panel.
//   clk, rst            - system clock, synchronous active-high reset
//   enable              - run request, honoured in IDLE and at frame end
//   fb_rd_en, fb_addr   - framebuffer read strobe and {row, col}
//   fb_rd_data          - {top pixel, bottom pixel}, 1 cycle read latency
//   rgb_top, rgb_bot    - current plane bits to the panel
//   display_clk, latch  - panel shift clock and latch
//   oe                  - panel output enable, active-low
//   row_addr, col_addr  - displayed row, column being shifted
//   frame_done          - one-cycle pulse after the last row's last plane
//
// state   | meaning
// IDLE    | outputs at rest, waiting for enable
// FETCH   | plane shift running; per-column FETCH/CLK_LO/CLK_HI live in the shift unit
// BLANK   | outputs blanked, row_addr updated
// LATCH   | latch pulse
// DISPLAY | oe low for BASE_ON_CYCLES << plane cycles
module hub75_bcm_scheduler
    import hub75_pkg::*;
#(
    parameter int ROWS           = 32,
    parameter int COLS           = 64,
    parameter int COLOR_BITS     = 4,
    parameter int CLK_DIV        = 2,
    parameter int BASE_ON_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic                     fb_rd_en,
    output logic [ROW_W+COL_W-1:0]   fb_addr,
    input  logic [2*PIX_W-1:0]       fb_rd_data,
    output logic [2:0]               rgb_top,
    output logic [2:0]               rgb_bot,
    output logic                     display_clk,
    output logic                     latch,
    output logic                     oe,
    output logic [ROW_W-1:0]         row_addr,
    output logic [COL_W-1:0]         col_addr,
    output logic                     frame_done
);

    localparam int ON_MAX = BASE_ON_CYCLES << (COLOR_BITS - 1);
    localparam int ON_W   = $clog2(ON_MAX + 1);

    state_t               state_q, state_d;
    logic [ROW_W-1:0]     row;
    logic [PLANE_W-1:0]   plane;
    logic [ON_W-1:0]      on_cnt;
    logic [ON_W-1:0]      on_load;
    logic                 on_tc;
    logic                 last_plane;
    logic                 last_row;
    logic                 frame_end;
    logic                 shift_start;
    logic                 shift_done;
    logic [2:0]           rgb_top_raw;
    logic [2:0]           rgb_bot_raw;
    logic [ROW_W-1:0]     row_addr_q;
    logic                 frame_done_q;

    assign on_load    = (ON_W'(BASE_ON_CYCLES) << plane) - ON_W'(1);
    assign on_tc      = (on_cnt == '0);
    assign last_plane = (plane == PLANE_W'(COLOR_BITS - 1));
    assign last_row   = (row == ROW_W'(ROWS - 1));
    assign frame_end  = last_plane && last_row;

    hub75_shift_unit #(
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .start       (shift_start),
        .row         (row),
        .plane       (plane),
        .fb_rd_data  (fb_rd_data),
        .fb_rd_en    (fb_rd_en),
        .fb_addr     (fb_addr),
        .col         (col_addr),
        .display_clk (display_clk),
        .rgb_top     (rgb_top_raw),
        .rgb_bot     (rgb_bot_raw),
        .done        (shift_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = FETCH;
            FETCH:   if (shift_done) state_d = BLANK;
            BLANK:   state_d = LATCH;
            LATCH:   state_d = DISPLAY;
            DISPLAY: if (on_tc) state_d = (frame_end && !enable) ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_start = (state_d == FETCH) && (state_q != FETCH);
        latch       = (state_q == LATCH);
        oe          = (state_q != DISPLAY);
        // The shift registers keep the last plane's bits; IDLE shows zeros instead.
        rgb_top     = (state_q == IDLE) ? 3'b000 : rgb_top_raw;
        rgb_bot     = (state_q == IDLE) ? 3'b000 : rgb_bot_raw;
        row_addr    = row_addr_q;
        frame_done  = frame_done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row          <= '0;
            plane        <= '0;
            on_cnt       <= '0;
            row_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= (state_q == DISPLAY) && on_tc && frame_end;

            if (state_q == LATCH) begin
                on_cnt <= on_load;
            end else if (state_q == DISPLAY && !on_tc) begin
                on_cnt <= on_cnt - ON_W'(1);
            end

            if (state_q == DISPLAY && on_tc) begin
                if (last_plane) begin
                    plane <= '0;
                    row   <= last_row ? '0 : row + ROW_W'(1);
                end else begin
                    plane <= plane + PLANE_W'(1);
                end
            end

            // row_addr moves only while blanked: in BLANK, or when dropping to IDLE.
            if (state_d == IDLE) begin
                row_addr_q <= '0;
            end else if (state_q == BLANK) begin
                row_addr_q <= row;
            end
        end
    end

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
module tb_hub75_bcm_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Distinct per-address pixel data so every plane and column differs.
    function automatic logic [23:0] pix(input logic [10:0] a);
        return {a[3:0], a[7:4], a[10:8], a[0], ~a[3:0], a[5:2], a[9:6]};
    endfunction

    function automatic logic [5:0] plane_exp(input logic [23:0] p, input logic [1:0] pl);
        logic [3:0] n;
        logic [5:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            n = 4'(p >> (20 - 4 * k));
            r = {r[4:0], n[pl]};
        end
        return r;
    endfunction

    // ---------------- DUT A: defaults ----------------
    logic        rst_a, en_a, rd_a, dclk_a, latch_a, oe_a, fd_a;
    logic [10:0] addr_a;
    logic [23:0] data_a;
    logic [2:0]  top_a, bot_a;
    logic [4:0]  row_a;
    logic [5:0]  col_a;

    hub75_bcm_scheduler dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .fb_rd_en(rd_a), .fb_addr(addr_a),
        .fb_rd_data(data_a), .rgb_top(top_a), .rgb_bot(bot_a), .display_clk(dclk_a),
        .latch(latch_a), .oe(oe_a), .row_addr(row_a), .col_addr(col_a), .frame_done(fd_a)
    );

    // ---------------- DUT B: CLK_DIV=3, BASE_ON_CYCLES=4 ----------------
    logic        rst_b, en_b, rd_b, dclk_b, latch_b, oe_b, fd_b;
    logic [10:0] addr_b;
    logic [23:0] data_b;
    logic [2:0]  top_b, bot_b;
    logic [4:0]  row_b;
    logic [5:0]  col_b;

    hub75_bcm_scheduler #(.CLK_DIV(3), .BASE_ON_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .fb_rd_en(rd_b), .fb_addr(addr_b),
        .fb_rd_data(data_b), .rgb_top(top_b), .rgb_bot(bot_b), .display_clk(dclk_b),
        .latch(latch_b), .oe(oe_b), .row_addr(row_b), .col_addr(col_b), .frame_done(fd_b)
    );

    // Framebuffer models: valid data exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        data_a <= rd_a ? pix(addr_a) : 24'h5AA_55A;
        data_b <= rd_b ? 24'hF00_00F : 24'h0FF_FF0;
    end

    // ---------------- monitor A ----------------
    int cyc_a = 0, fetch_cnt_a = 0, rise_cnt_a = 0, latch_cnt_a = 0, oe_run_a = 0, fd_cnt_a = 0;
    int t_fetch0_a = 0, t_latch0_a = 0, t_fd_a = 0;
    int bad_addr_a = 0, bad_rgb_a = 0, bad_ctl_a = 0, bad_row_a = 0;
    int on_len_a[$];
    logic [10:0] last_addr_a = '0;
    logic prv_dclk_a = 1'b0, prv_latch_a = 1'b0, prv_oe_a = 1'b1, prv_fd_a = 1'b0;
    logic [4:0] prv_row_a = '0;

    always @(negedge clk) begin
        logic [10:0] ea;
        cyc_a++;
        if (rd_a) begin
            ea = {5'((latch_cnt_a / 4) % 32), 6'(fetch_cnt_a % 64)};
            if (addr_a !== ea) bad_addr_a++;
            if (col_a !== ea[5:0]) bad_addr_a++;
            if (fetch_cnt_a == 0) t_fetch0_a = cyc_a;
            last_addr_a = addr_a;
            fetch_cnt_a++;
        end
        if (dclk_a && !prv_dclk_a) begin
            if ({top_a, bot_a} !== plane_exp(pix(last_addr_a), 2'(latch_cnt_a % 4))) bad_rgb_a++;
            rise_cnt_a++;
        end
        if (latch_a) begin
            if (!oe_a || dclk_a || prv_latch_a) bad_ctl_a++;
            if (latch_cnt_a == 0) t_latch0_a = cyc_a;
            latch_cnt_a++;
        end
        if (!oe_a) begin
            if (prv_oe_a && row_a !== 5'(((latch_cnt_a - 1) / 4) % 32)) bad_row_a++;
            if (row_a !== prv_row_a) bad_row_a++;
            if (dclk_a) bad_ctl_a++;
            oe_run_a++;
        end else if (!prv_oe_a) begin
            on_len_a.push_back(oe_run_a);
            oe_run_a = 0;
        end
        if (fd_a) begin
            if (prv_fd_a) bad_ctl_a++;
            fd_cnt_a++;
            t_fd_a = cyc_a;
        end
        prv_dclk_a  = dclk_a;
        prv_latch_a = latch_a;
        prv_oe_a    = oe_a;
        prv_fd_a    = fd_a;
        prv_row_a   = row_a;
    end

    task automatic clear_a();
        fetch_cnt_a = 0; rise_cnt_a = 0; latch_cnt_a = 0; oe_run_a = 0; fd_cnt_a = 0;
        on_len_a.delete();
    endtask

    // ---------------- monitor B ----------------
    int cyc_b = 0, fetch_cnt_b = 0, rise_cnt_b = 0, latch_cnt_b = 0, oe_run_b = 0;
    int t_fetch0_b = 0, t_latch0_b = 0, t_rise_b = 0, hi_run_b = 0;
    int bad_clk_b = 0, bad_rgb_b = 0;
    int on_len_b[$];
    logic prv_dclk_b = 1'b0, prv_oe_b = 1'b1;

    always @(negedge clk) begin
        cyc_b++;
        if (rd_b) begin
            if (fetch_cnt_b == 0) t_fetch0_b = cyc_b;
            fetch_cnt_b++;
        end
        if (dclk_b) hi_run_b++;
        if (dclk_b && !prv_dclk_b) begin
            if (rise_cnt_b % 64 != 0 && cyc_b - t_rise_b != 7) bad_clk_b++;
            t_rise_b = cyc_b;
            if ({top_b, bot_b} !== 6'b100_001) bad_rgb_b++;
            rise_cnt_b++;
        end
        if (!dclk_b && prv_dclk_b) begin
            if (hi_run_b != 3) bad_clk_b++;
            hi_run_b = 0;
        end
        if (latch_b) begin
            if (latch_cnt_b == 0) t_latch0_b = cyc_b;
            latch_cnt_b++;
        end
        if (!oe_b) begin
            oe_run_b++;
        end else if (!prv_oe_b) begin
            on_len_b.push_back(oe_run_b);
            oe_run_b = 0;
        end
        prv_dclk_b = dclk_b;
        prv_oe_b   = oe_b;
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int bad_on;
        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        fork
            begin : seq_a
                repeat (3) @(negedge clk);
                #1;
                check("rst_ctl", {oe_a, latch_a, dclk_a, rd_a, fd_a}, 5'b10000);
                check("rst_rgb", {top_a, bot_a}, 6'b0);
                check("rst_rowcol", {row_a, col_a}, 11'd0);
                clear_a();
                rst_a = 1'b0;
                en_a  = 1'b1;
                @(negedge clk); #1;
                check("first_fetch", {rd_a, addr_a}, {1'b1, 11'd0});

                n = 0;
                while (latch_cnt_a < 1 && n < 2000) begin @(negedge clk); #1; n++; end
                check("latch0_seen", n < 2000, 1);
                check("latch0_offset", t_latch0_a - t_fetch0_a, 321);
                check("rises_plane0", rise_cnt_a, 64);

                n = 0;
                while (on_len_a.size() < 4 && n < 3000) begin @(negedge clk); #1; n++; end
                check("row0_planes_seen", n < 3000, 1);
                check("on_plane0", on_len_a[0], 8);
                check("on_plane1", on_len_a[1], 16);
                check("on_plane2", on_len_a[2], 32);
                check("on_plane3", on_len_a[3], 64);

                n = 0;
                while (latch_cnt_a < 41 && n < 20000) begin @(negedge clk); #1; n++; end
                check("row10_seen", n < 20000, 1);
                en_a = 1'b0;

                n = 0;
                while (fd_cnt_a < 1 && n < 50000) begin @(negedge clk); #1; n++; end
                check("frame_done_seen", n < 50000, 1);
                check("frame_len", t_fd_a - t_fetch0_a, 45056);
                check("idle_ctl", {oe_a, latch_a, dclk_a, rd_a}, 4'b1000);
                check("idle_row", row_a, 5'd0);
                check("idle_rgb", {top_a, bot_a}, 6'b0);
                repeat (100) @(negedge clk);
                #1;
                check("idle_no_fetch", fetch_cnt_a, 8192);
                check("idle_oe", oe_a, 1'b1);
                check("frame_pulses", fd_cnt_a, 1);
                check("frame_latches", latch_cnt_a, 128);
                check("frame_rises", rise_cnt_a, 8192);
                check("frame_on_count", on_len_a.size(), 128);
                bad_on = 0;
                foreach (on_len_a[i]) if (on_len_a[i] != (8 << (i % 4))) bad_on++;
                check("frame_on_pattern", bad_on, 0);

                // Restart, then reset in the middle of row 5 plane 3.
                clear_a();
                en_a = 1'b1;
                n = 0;
                while (!(latch_cnt_a == 24 && !oe_a) && n < 10000) begin @(negedge clk); #1; n++; end
                check("row5_p3_seen", n < 10000, 1);
                repeat (10) @(negedge clk);
                #1;
                check("row5_addr", row_a, 5'd5);
                rst_a = 1'b1;
                @(negedge clk); #1;
                check("mid_rst_ctl", {oe_a, latch_a, dclk_a, rd_a, fd_a}, 5'b10000);
                check("mid_rst_rgb", {top_a, bot_a}, 6'b0);
                check("mid_rst_rowcol", {row_a, col_a}, 11'd0);
                clear_a();
                rst_a = 1'b0;
                @(negedge clk); #1;
                check("restart_fetch", {rd_a, addr_a}, {1'b1, 11'd0});
                n = 0;
                while (on_len_a.size() < 1 && n < 1000) begin @(negedge clk); #1; n++; end
                check("restart_on_seen", n < 1000, 1);
                check("restart_on0", on_len_a[0], 8);
                en_a = 1'b0;

                check("addr_errors", bad_addr_a, 0);
                check("rgb_errors", bad_rgb_a, 0);
                check("ctl_overlap_errors", bad_ctl_a, 0);
                check("row_errors", bad_row_a, 0);
            end
            begin : seq_b
                repeat (3) @(negedge clk);
                #1;
                rst_b = 1'b0;
                en_b  = 1'b1;
                n = 0;
                while (on_len_b.size() < 4 && n < 3000) begin @(negedge clk); #1; n++; end
                check("b_row0_seen", n < 3000, 1);
                check("b_shift_len", t_latch0_b - t_fetch0_b, 449);
                check("b_on0", on_len_b[0], 4);
                check("b_on1", on_len_b[1], 8);
                check("b_on2", on_len_b[2], 16);
                check("b_on3", on_len_b[3], 32);
                check("b_rises", rise_cnt_b, 256);
                check("b_clk_phase_errors", bad_clk_b, 0);
                check("b_rgb_errors", bad_rgb_b, 0);
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
